// File: rtl/regfile_dump_pkg.sv
// Shared CPU defines plus the register-dump FSM encodings.
package regfile_dump_pkg;

  localparam int unsigned NIBBLE = 4;
  localparam int unsigned WORD   = 32;
  localparam int unsigned REGNUM = 8;
  localparam logic [NIBBLE-1:0] NOREG = 4'hF;

  // Bytes emitted per register pair (two words per latch).
  localparam int unsigned DUMP_BYTES_PER_PAIR = 2 * WORD / 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StHalt   = 3'd1,
    StLatch  = 3'd2,
    StSend   = 3'd3,
    StFinish = 3'd4
  } dump_state_e;

  // Number of stream bytes needed to carry one register pair.
  function automatic int unsigned pair_bytes(input int unsigned word_w, input int unsigned byte_w);
    return 2 * word_w / byte_w;
  endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// Register-file read ports and outgoing byte stream seen by the dump unit.
interface regfile_dump_if
  import regfile_dump_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BYTE_W = 8
);

  logic [NIBBLE-1:0] srcA;
  logic [NIBBLE-1:0] srcB;
  logic [WORD_W-1:0] valA;
  logic [WORD_W-1:0] valB;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  // Dump unit side: drives read addresses and the stream.
  modport master (
    output srcA, srcB, tx_data, tx_valid,
    input  valA, valB, tx_ready
  );

  // Register file / sink side.
  modport slave (
    input  srcA, srcB, tx_data, tx_valid,
    output valA, valB, tx_ready
  );

endinterface

// File: rtl/regfile_dump_serializer.sv
// Pair buffer, byte counter and valid/ready output stage for the register dump.
module regfile_dump_serializer
  import regfile_dump_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BYTE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                load,
  input  logic                active,
  input  logic [2*WORD_W-1:0] load_data,
  output logic [BYTE_W-1:0]   tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                pair_done
);

  localparam int unsigned PairBytes = pair_bytes(WORD_W, BYTE_W);
  localparam int unsigned CntW      = (PairBytes > 1) ? $clog2(PairBytes) : 1;

  logic [2*WORD_W-1:0] shift_q;
  logic [CntW-1:0]     cnt_q;
  logic                accept;

  // Handshake completes only while the FSM holds us in the send phase.
  always_comb begin
    accept    = active && tx_ready;
    tx_valid  = active;
    tx_data   = active ? shift_q[BYTE_W-1:0] : '0;
    pair_done = accept && (cnt_q == CntW'(PairBytes - 1));
  end

  // Load a fresh pair, or shift out one byte per accepted transfer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= load_data;
      cnt_q   <= '0;
    end else if (accept) begin
      shift_q <= shift_q >> BYTE_W;
      cnt_q   <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/regfile_dump.sv
// Debug reader: halts the pipeline and streams every register out as bytes.
module regfile_dump #(
  parameter int unsigned REGNUM = 8,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BYTE_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            halt_ack,
  output logic            halt_req,
  regfile_dump_if.master  bus,
  output logic            busy,
  output logic            done
);

  import regfile_dump_pkg::*;

  localparam logic [NIBBLE-1:0] LastIdx = NIBBLE'(REGNUM - 2);

  dump_state_e       state_q, state_d;
  logic [NIBBLE-1:0] index_q, index_d;
  logic              pair_done;
  logic              ser_load;
  logic              ser_active;

  // Next-state and index update; abort from any active state wins over everything.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) state_d = StHalt;
      end
      StHalt: begin
        if (halt_ack) state_d = StLatch;
      end
      StLatch: begin
        state_d = StSend;
      end
      StSend: begin
        if (pair_done) begin
          if (index_q == LastIdx) begin
            state_d = StFinish;
          end else begin
            index_d = index_q + NIBBLE'(2);
            state_d = StLatch;
          end
        end
      end
      StFinish: begin
        index_d = '0;
        state_d = StIdle;
      end
      default: begin
        index_d = '0;
        state_d = StIdle;
      end
    endcase
    if (abort && (state_q != StIdle)) begin
      index_d = '0;
      state_d = StIdle;
    end
  end

  // State and register-pair index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  // Status and read-port addressing decoded from state; ports idle at NOREG.
  always_comb begin
    halt_req   = (state_q == StHalt) || (state_q == StLatch) || (state_q == StSend);
    busy       = halt_req;
    done       = (state_q == StFinish);
    ser_load   = (state_q == StLatch);
    ser_active = (state_q == StSend);
    bus.srcA   = ser_load ? index_q : NOREG;
    bus.srcB   = ser_load ? (index_q + NIBBLE'(1)) : NOREG;
  end

  regfile_dump_serializer #(
    .WORD_W (WORD_W),
    .BYTE_W (BYTE_W)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .load      (ser_load),
    .active    (ser_active),
    .load_data ({bus.valB, bus.valA}),
    .tx_data   (bus.tx_data),
    .tx_valid  (bus.tx_valid),
    .tx_ready  (bus.tx_ready),
    .pair_done (pair_done)
  );

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: expected bytes queued at start, checked by a monitor.
module tb_regfile_dump;

  logic clk = 1'b0;
  logic rst, start, abort, halt_ack;
  logic halt_req, busy, done;

  always #5 clk = ~clk;

  regfile_dump_if #(.WORD_W(32), .BYTE_W(8)) bus ();

  regfile_dump #(
    .REGNUM (8),
    .WORD_W (32),
    .BYTE_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .halt_ack (halt_ack),
    .halt_req (halt_req),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  // Register file model with combinational read ports; index 15 (NOREG) reads 0.
  logic [31:0] rf [16];
  assign bus.valA = rf[bus.srcA];
  assign bus.valB = rf[bus.srcB];

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  rx_log [$];
  int          done_cnt = 0;
  bit          ready_toggle = 1'b0;
  bit          ready_en = 1'b1;
  bit          hold_prev = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected();
    for (int r = 0; r < 8; r++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(rf[r][8*b +: 8]);
  endtask

  task automatic start_dump();
    push_expected();
    rx_log.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic ack_after(input int n);
    repeat (n) tick();
    halt_ack = 1'b1;
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_cnt == base && n < 3000) begin
      tick();
      n++;
    end
    if (done_cnt == base) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done");
    end
    halt_ack = 1'b0;
  endtask

  task automatic wait_bytes(input int nbytes);
    int n = 0;
    while (rx_log.size() < nbytes && n < 3000) begin
      tick();
      n++;
    end
    if (rx_log.size() < nbytes) begin
      checks++;
      errors++;
      $display("FAIL bytes_timeout actual=%0d required=%0d", rx_log.size(), nbytes);
    end
  endtask

  // Sink ready: always-on, alternating, or held low.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      tick();
      if (ready_toggle) bus.tx_ready = ~bus.tx_ready;
      else              bus.tx_ready = ready_en;
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks stream stability.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (hold_prev) begin
          check("hold_valid", 64'(bus.tx_valid), 64'd1);
          check("hold_data", 64'(bus.tx_data), 64'(prev_data));
        end
        if (bus.tx_valid && bus.tx_ready && !abort) begin
          rx_log.push_back(bus.tx_data);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", bus.tx_data);
          end else begin
            check("stream_byte", 64'(bus.tx_data), 64'(exp_q.pop_front()));
          end
        end
        if (done) begin
          done_cnt++;
          check("done_halt_req", 64'(halt_req), 64'd0);
          check("done_busy", 64'(busy), 64'd0);
        end
      end
      hold_prev = bus.tx_valid && !bus.tx_ready && !abort && !rst;
      prev_data = bus.tx_data;
    end
  end

  logic [7:0] first8 [8];
  logic [7:0] last4 [4];
  logic [7:0] beef4 [4];

  initial begin
    first8 = '{8'h67, 8'h45, 8'h23, 8'h01, 8'h89, 8'h67, 8'h45, 8'h23};
    last4  = '{8'hEF, 8'hCD, 8'hAB, 8'h89};
    beef4  = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    rf[0] = 32'h0123_4567; rf[1] = 32'h2345_6789; rf[2] = 32'h4567_89AB;
    rf[3] = 32'h6789_ABCD; rf[4] = 32'h89AB_CDEF; rf[5] = 32'hABCD_EF01;
    rf[6] = 32'hCDEF_0123; rf[7] = 32'h89AB_CDEF;
    rst = 1'b1; start = 1'b0; abort = 1'b0; halt_ack = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_halt_req", 64'(halt_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("rst_tx_data", 64'(bus.tx_data), 64'd0);
    check("rst_srcA", 64'(bus.srcA), 64'hF);
    check("rst_srcB", 64'(bus.srcB), 64'hF);
    rst = 1'b0;
    tick();

    // Full dump, ready always high.
    start_dump();
    ack_after(3);
    wait_done(0);
    check("t1_count", 64'(rx_log.size()), 64'd32);
    for (int i = 0; i < 8; i++) check("t1_first8", 64'(rx_log[i]), 64'(first8[i]));
    for (int i = 0; i < 4; i++) check("t1_last4", 64'(rx_log[28+i]), 64'(last4[i]));
    repeat (3) tick();
    check("t1_done_once", 64'(done_cnt), 64'd1);

    // Backpressure: ready alternates.
    ready_toggle = 1'b1;
    start_dump();
    ack_after(3);
    wait_done(1);
    ready_toggle = 1'b0;
    tick();
    check("t2_count", 64'(rx_log.size()), 64'd32);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Long halt wait: nothing moves, read ports parked.
    start_dump();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_no_valid", 64'(bus.tx_valid), 64'd0);
      check("t3_srcA", 64'(bus.srcA), 64'hF);
      check("t3_srcB", 64'(bus.srcB), 64'hF);
    end
    halt_ack = 1'b1;
    wait_done(2);
    check("t3_count", 64'(rx_log.size()), 64'd32);

    // Abort after the 10th byte.
    start_dump();
    ack_after(3);
    wait_bytes(10);
    abort = 1'b1;
    ready_en = 1'b0;
    bus.tx_ready = 1'b0;
    tick();
    abort = 1'b0;
    check("t4_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_halt_req", 64'(halt_req), 64'd0);
    check("t4_done", 64'(done), 64'd0);
    exp_q.delete();
    halt_ack = 1'b0;
    ready_en = 1'b1;
    repeat (5) tick();
    check("t4_no_done", 64'(done_cnt), 64'd3);
    start_dump();
    ack_after(3);
    wait_done(3);
    check("t4_restart_first", 64'(rx_log[0]), 64'h67);
    check("t4_restart_count", 64'(rx_log.size()), 64'd32);

    // Start pulsed mid-dump is ignored.
    start_dump();
    ack_after(3);
    wait_bytes(12);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(4);
    repeat (4) tick();
    check("t5_count", 64'(rx_log.size()), 64'd32);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t5_idle_busy", 64'(busy), 64'd0);
    check("t5_done_cnt", 64'(done_cnt), 64'd5);

    // Synchronous reset during SEND.
    start_dump();
    ack_after(3);
    wait_bytes(5);
    rst = 1'b1;
    tick();
    check("t6_halt_req", 64'(halt_req), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("t6_tx_data", 64'(bus.tx_data), 64'd0);
    check("t6_srcA", 64'(bus.srcA), 64'hF);
    check("t6_srcB", 64'(bus.srcB), 64'hF);
    rst = 1'b0;
    halt_ack = 1'b0;
    exp_q.delete();
    tick();

    // Write-back to reg 2 before the dump shows up in its byte slot.
    rf[2] = 32'hDEAD_BEEF;
    start_dump();
    ack_after(3);
    wait_done(5);
    for (int i = 0; i < 4; i++) check("t7_reg2", 64'(rx_log[8+i]), 64'(beef4[i]));
    check("t7_count", 64'(rx_log.size()), 64'd32);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
